// File: rtl/mac_pkg.sv
// Shared types and the saturating/wrapping accumulate helper for the MAC tile.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } mac_state_t;

  localparam int SA_W = 64;
  localparam logic signed [SA_W:0] SA_ONE = (SA_W+1)'(1);

  // Returns {ovf, sum}; sum is meaningful in its low acc_w bits (acc_w <= SA_W).
  function automatic logic [SA_W:0] sat_add(input logic signed [SA_W-1:0] acc,
                                            input logic signed [SA_W-1:0] p,
                                            input logic sat,
                                            input int acc_w);
    logic signed [SA_W:0] s;
    logic signed [SA_W:0] hi;
    logic signed [SA_W:0] lo;
    logic [SA_W-1:0]      sum;
    logic                 ovf;
    s   = (SA_W+1)'(acc) + (SA_W+1)'(p);
    hi  = (SA_ONE <<< (acc_w - 1)) - SA_ONE;
    lo  = -hi - SA_ONE;
    ovf = 1'b0;
    sum = s[SA_W-1:0];
    if (s > hi) begin
      ovf = 1'b1;
      if (sat) sum = hi[SA_W-1:0];
    end else if (s < lo) begin
      ovf = 1'b1;
      if (sat) sum = lo[SA_W-1:0];
    end
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/mac_tile_acc_if.sv
// Operand-in / result-row-out bus of the MAC tile, plus the tile control strobes.
interface mac_tile_acc_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 16
);
  logic                     clr;
  logic                     cfg_sat;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_a;
  logic [COLS*DATA_W-1:0]   in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    out_row;
  logic [$clog2(ROWS):0]    out_idx;
  logic [K_W-1:0]           out_k;
  logic                     out_ovf;

  modport master (
    output clr, cfg_sat, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_row, out_idx, out_k, out_ovf
  );

  modport slave (
    input  clr, cfg_sat, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_row, out_idx, out_k, out_ovf
  );
endinterface

// File: rtl/mac_cell.sv
// One accumulator of the tile: loads the product on a tile's first beat, adds later.
module mac_cell
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_add,
  input  logic                     i_sat,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_ovf
);

  logic signed [2*DATA_W-1:0] w_p;
  logic [SA_W:0]              w_res;

  assign w_p   = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_res = sat_add(SA_W'(o_acc), SA_W'(w_p), i_sat, ACC_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (i_load) begin
      o_acc <= ACC_W'(w_p);
      o_ovf <= 1'b0;
    end else if (i_add) begin
      o_acc <= ACC_W'(w_res[SA_W-1:0]);
      o_ovf <= o_ovf | w_res[SA_W];
    end
  end

endmodule

// File: rtl/mac_tile_acc.sv
// Output-stationary ROWSxCOLS outer-product accumulator tile with row-by-row drain.
module mac_tile_acc
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 16
) (
  input logic          clk,
  input logic          rst,
  mac_tile_acc_if.slave bus
);

  localparam int IDX_W = $clog2(ROWS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  mac_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [K_W-1:0]   r_k;
  logic             r_sat;

  logic             w_rdy;
  logic             w_beat;
  logic             w_load;
  logic             w_add;
  logic [COLS*ACC_W-1:0] w_row;
  wire  [COLS*ACC_W-1:0] w_rows [ROWS];
  wire  [ROWS*COLS-1:0]  w_ovf;

  // clr gates the handshake so an aborted cycle never loads a beat.
  assign w_rdy  = (r_state != DRAIN) && !bus.clr;
  assign w_beat = bus.in_valid && w_rdy;
  assign w_load = w_beat && (r_state == IDLE);
  assign w_add  = w_beat && (r_state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_k     <= '0;
      r_sat   <= 1'b0;
    end else if (bus.clr) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_state <= bus.in_last ? DRAIN : ACCUM;
            r_k     <= K_W'(1);
            r_sat   <= bus.cfg_sat;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            if (bus.in_last) r_state <= DRAIN;
            if (r_k != '1) r_k <= r_k + K_W'(1);
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic signed [ACC_W-1:0] w_acc;
      logic                    w_cell_ovf;
      mac_cell #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load),
        .i_add (w_add),
        .i_sat (r_sat),
        .i_a   (bus.in_a[gr*DATA_W +: DATA_W]),
        .i_b   (bus.in_b[gc*DATA_W +: DATA_W]),
        .o_acc (w_acc),
        .o_ovf (w_cell_ovf)
      );
      assign w_rows[gr][gc*ACC_W +: ACC_W] = w_acc;
      assign w_ovf[gr*COLS + gc]           = w_cell_ovf;
    end
  end

  always_comb begin
    w_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_idx == IDX_W'(r)) w_row = w_rows[r];
    end
  end

  assign bus.in_ready  = w_rdy;
  assign bus.out_valid = (r_state == DRAIN);
  assign bus.out_row   = w_row;
  assign bus.out_idx   = r_idx;
  assign bus.out_k     = r_k;
  assign bus.out_ovf   = |w_ovf;

endmodule
